// File: rtl/data_mem_responder.sv
// data_mem_responder: serves memread/memwrite level requests from a 16-bit synchronous RAM with programmable wait states
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   memread, memwrite   request levels, held by the requester until ready, then dropped
//   addr, wdata         word address (upper bits beyond ADDR_WIDTH must be zero), write data
//   rdata               registered read data, updated only by a completed read
//   ready, err          one-cycle completion / rejection pulses
//   busy                high from acceptance until return to idle
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE, S_RELEASE} state_t;
    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [15:0]             r_wdata;
    logic [15:0]             r_mem [2**ADDR_WIDTH];
    logic                    w_one;
    logic                    w_both;
    logic                    w_bad;
    assign w_one  = memread ^ memwrite;
    assign w_both = memread & memwrite;
    assign w_bad  = (addr >> ADDR_WIDTH) != 16'd0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_both || (w_one && w_bad)) begin
                        err     <= 1'b1;
                        r_state <= S_RELEASE;
                    end else if (w_one) begin
                        r_we    <= memwrite;
                        r_addr  <= addr[ADDR_WIDTH-1:0];
                        r_wdata <= wdata;
                        busy    <= 1'b1;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // leaving on count 1 makes WAIT last exactly WAIT_STATES cycles
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!r_we) rdata <= r_mem[r_addr];
                    ready   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: r_state <= S_RELEASE;
                S_RELEASE: begin
                    // wait for the handshake to close so a held request is not served twice
                    if (!memread && !memwrite) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    // contents are not reset; reset forces IDLE so a pending write never commits
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_we) r_mem[r_addr] <= r_wdata;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table-driven checks of data_mem_responder with 2 and 0 wait states
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite;
    logic [15:0] addr, wdata;
    logic [15:0] rdata2, rdata0;
    logic        ready2, busy2, err2, ready0, busy0, err0;
    int          checks = 0;
    int          errors = 0;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .wdata(wdata), .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2));

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));

    always #5 clk = ~clk;

    typedef struct {
        bit          w2;
        bit          rd;
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        int          hold;
        int          lat;
        int          elat;
        int          nrdy;
        int          nbusy;
        logic [15:0] rdat;
    } vec_t;

    vec_t v [14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run(input vec_t t, output int lat, output int elat, output int nrdy,
                       output int nbusy, output logic [15:0] rda);
        int   rel;
        logic r, e, b;
        lat = -1; elat = -1; nrdy = 0; nbusy = 0; rda = 'x; rel = -1;
        @(negedge clk);
        memread = t.rd; memwrite = t.wr; addr = t.a; wdata = t.d;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            r = t.w2 ? ready2 : ready0;
            e = t.w2 ? err2 : err0;
            b = t.w2 ? busy2 : busy0;
            if ((ready2 && err2) || (ready0 && err0)) begin
                errors++;
                $display("FAIL ready_err_overlap at cycle %0d", c);
            end
            if (b) nbusy++;
            if (r) begin
                nrdy++;
                if (lat < 0) begin
                    lat = c;
                    rda = t.w2 ? rdata2 : rdata0;
                end
            end
            if (e && elat < 0) elat = c;
            if ((r || e) && rel < 0) rel = c + t.hold;
            if (c == rel) begin
                memread = 1'b0; memwrite = 1'b0;
            end
            if (rel >= 0 && c > rel && !busy2 && !busy0) break;
        end
        memread = 1'b0; memwrite = 1'b0;
    endtask

    task automatic apply(input int i, input vec_t t);
        int          lat, elat, nrdy, nbusy;
        logic [15:0] rda;
        run(t, lat, elat, nrdy, nbusy, rda);
        chk($sformatf("v%0d_ready_latency", i), lat, t.lat);
        chk($sformatf("v%0d_err_latency", i), elat, t.elat);
        chk($sformatf("v%0d_ready_count", i), nrdy, t.nrdy);
        chk($sformatf("v%0d_busy_cycles", i), nbusy, t.nbusy);
        chk($sformatf("v%0d_rdata_final", i), t.w2 ? rdata2 : rdata0, t.rdat);
        if (t.nrdy > 0) chk($sformatf("v%0d_rdata_at_ready", i), rda, t.rdat);
    endtask

    initial begin
        //        w2 rd wr addr      wdata     hold lat elat nrdy busy rdata
        v[0]  = '{0, 0, 1, 16'h0000, 16'h1234, 0,   2, -1,  1,   3,   16'h0000};
        v[1]  = '{0, 1, 0, 16'h0000, 16'h0000, 0,   2, -1,  1,   3,   16'h1234};
        v[2]  = '{1, 0, 1, 16'h0005, 16'hBEEF, 0,   4, -1,  1,   5,   16'h1234};
        v[3]  = '{1, 1, 0, 16'h0005, 16'h0000, 0,   4, -1,  1,   5,   16'hBEEF};
        v[4]  = '{1, 0, 1, 16'h0003, 16'h1111, 0,   4, -1,  1,   5,   16'hBEEF};
        v[5]  = '{1, 1, 0, 16'h0003, 16'h0000, 0,   4, -1,  1,   5,   16'h1111};
        v[6]  = '{1, 1, 0, 16'h0005, 16'h0000, 0,   4, -1,  1,   5,   16'hBEEF};
        v[7]  = '{1, 1, 1, 16'h0003, 16'h2222, 0,  -1,  1,  0,   0,   16'hBEEF};
        v[8]  = '{1, 1, 0, 16'h0003, 16'h0000, 0,   4, -1,  1,   5,   16'h1111};
        v[9]  = '{1, 1, 0, 16'h0400, 16'h0000, 0,  -1,  1,  0,   0,   16'h1111};
        v[10] = '{1, 1, 0, 16'h0000, 16'h0000, 0,   4, -1,  1,   5,   16'h1234};
        v[11] = '{1, 0, 1, 16'h8005, 16'h9999, 0,  -1,  1,  0,   0,   16'h1234};
        v[12] = '{1, 1, 0, 16'h0005, 16'h0000, 10,  4, -1,  1,   14,  16'hBEEF};
        v[13] = '{0, 1, 0, 16'h0003, 16'h0000, 3,   2, -1,  1,   5,   16'h1111};

        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_rdata", rdata2, 16'h0000);
        chk("reset_ready", ready2, 1'b0);
        chk("reset_busy", busy2, 1'b0);
        chk("reset_err", err2, 1'b0);
        chk("reset_busy_w0", busy0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) apply(i, v[i]);

        apply(14, '{1, 0, 1, 16'h0007, 16'h00FF, 0, 4, -1, 1, 5, 16'h1111});
        @(negedge clk);
        memwrite = 1'b1; addr = 16'h0007; wdata = 16'hAAAA;
        @(negedge clk);
        chk("abort_busy_before_reset", busy2, 1'b1);
        @(negedge clk);
        reset = 1'b1; memwrite = 1'b0;
        #1;
        chk("abort_rdata", rdata2, 16'h0000);
        chk("abort_ready", ready2, 1'b0);
        chk("abort_busy", busy2, 1'b0);
        chk("abort_err", err2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        apply(15, '{1, 1, 0, 16'h0007, 16'h0000, 0, 4, -1, 1, 5, 16'h00FF});
        chk("committed_write_w0", rdata0, 16'hAAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
